// File: rtl/cen_clkgen.sv
// cen_clkgen: fractional-rate clock-enable generator
// with PLL-lock qualification and runtime ratio control.
module cen_clkgen #(
  parameter int NCH = 4,
  parameter int W = 16,
  parameter logic [NCH*W-1:0] NUM_INIT = {NCH{16'd1}},
  parameter logic [NCH*W-1:0] DEN_INIT = {NCH{16'd4}},
  parameter int LOCK_CYCLES = 1024
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           pll_locked,
  input  logic           pause,
  input  logic           cfg_wr,
  input  logic [2:0]     cfg_ch,
  input  logic [W-1:0]   cfg_num,
  input  logic [W-1:0]   cfg_den,
  output logic [NCH-1:0] cen,
  output logic [NCH-1:0] cen_b,
  output logic           ready,
  output logic           rst_out_n
);

  localparam int CW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_QUAL,
    S_RUN
  } lock_st_t;

  logic          sync1;
  logic          lk;
  logic [CW-1:0] lock_cnt;
  logic          cnt_full;
  lock_st_t      st_q;
  lock_st_t      st_d;
  logic          halt;

  assign cnt_full = (lock_cnt == CW'(LOCK_CYCLES));

  // two-flop synchroniser for the asynchronous lock input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      lk    <= 1'b0;
    end else begin
      sync1 <= pll_locked;
      lk    <= sync1;
    end
  end

  // consecutive-lock counter, saturating at LOCK_CYCLES
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt <= '0;
    end else if (!lk) begin
      lock_cnt <= '0;
    end else if (!cnt_full) begin
      lock_cnt <= lock_cnt + CW'(1);
    end
  end

  // lock sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= S_IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  // lock sequencer next state: any lk drop restarts qualification
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      S_IDLE: begin
        if (lk) st_d = S_QUAL;
      end
      S_QUAL: begin
        if (!lk) st_d = S_IDLE;
        else if (cnt_full) st_d = S_RUN;
      end
      S_RUN: begin
        if (!lk) st_d = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end

  // lock sequencer outputs
  always_comb begin
    ready = (st_q == S_RUN);
  end

  // downstream reset, registered copy of the release decision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_out_n <= 1'b0;
    end else begin
      rst_out_n <= (st_d == S_RUN);
    end
  end

  // channels clear as soon as lk drops, one edge ahead of ready
  assign halt = !lk || !ready;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [W-1:0] num_q;
    logic [W-1:0] den_q;
    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;
    logic [W-1:0] half;
    logic [W:0]   sum;
    logic         wr_hit;
    logic         fast;
    logic         cen_q;
    logic         cenb_q;
    logic         cen_d;
    logic         cenb_d;

    assign wr_hit = cfg_wr && (cfg_ch == 3'(i));
    assign half   = den_q >> 1;
    assign sum    = {1'b0, acc_q} + {1'b0, num_q};
    assign fast   = {num_q, 1'b0} > {1'b0, den_q};

    // next accumulator and pulse decision for this channel
    always_comb begin
      acc_d  = acc_q;
      cen_d  = 1'b0;
      cenb_d = 1'b0;
      if (wr_hit || halt) begin
        acc_d = '0;
      end else if (pause) begin
        acc_d = acc_q;
      end else if (den_q == '0) begin
        acc_d = '0;
      end else if (sum >= {1'b0, den_q}) begin
        cen_d = 1'b1;
        if (num_q > den_q) acc_d = '0;
        else acc_d = acc_q + num_q - den_q;
      end else begin
        acc_d  = sum[W-1:0];
        cenb_d = !fast && (acc_q < half) &&
                 (sum >= {1'b0, half});
      end
    end

    // ratio, accumulator and pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        num_q  <= NUM_INIT[i*W +: W];
        den_q  <= DEN_INIT[i*W +: W];
        acc_q  <= '0;
        cen_q  <= 1'b0;
        cenb_q <= 1'b0;
      end else begin
        if (wr_hit) begin
          num_q <= cfg_num;
          den_q <= cfg_den;
        end
        acc_q  <= acc_d;
        cen_q  <= cen_d;
        cenb_q <= cenb_d;
      end
    end

    assign cen[i]   = cen_q;
    assign cen_b[i] = cenb_q;
  end

endmodule

// File: tb/tb_cen_clkgen.sv
// tb_cen_clkgen: randomized scoreboard bench for
// cen_clkgen against a rate-based reference model.
module tb_cen_clkgen;
  localparam int NCH = 4;
  localparam int W = 16;
  localparam int LC = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pll_locked = 1'b0;
  logic pause = 1'b0;
  logic cfg_wr = 1'b0;
  logic [2:0] cfg_ch = '0;
  logic [W-1:0] cfg_num = '0;
  logic [W-1:0] cfg_den = '0;
  logic [NCH-1:0] cen;
  logic [NCH-1:0] cen_b;
  logic ready;
  logic rst_out_n;

  cen_clkgen #(
    .NCH(NCH),
    .W(W),
    .LOCK_CYCLES(LC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pll_locked(pll_locked),
    .pause(pause),
    .cfg_wr(cfg_wr),
    .cfg_ch(cfg_ch),
    .cfg_num(cfg_num),
    .cfg_den(cfg_den),
    .cen(cen),
    .cen_b(cen_b),
    .ready(ready),
    .rst_out_n(rst_out_n)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic           rdy;
    logic           rst;
    logic [NCH-1:0] c;
    logic [NCH-1:0] b;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int pc[NCH];
  int pcb[NCH];
  int cyc_no = 0;

  longint m_num[NCH];
  longint m_den[NCH];
  longint m_k[NCH];
  bit m_s1, m_lk, m_rdy;
  int m_run;

  // enable on the k-th enabled step: floor(k*n/d) advanced
  function automatic bit f_cen(longint n, longint d, longint k);
    if (d == 0) return 1'b0;
    if (n > d) return 1'b1;
    return (k * n) / d != ((k - 1) * n) / d;
  endfunction

  // companion: running total crossed a half-period point
  function automatic bit f_cenb(longint n, longint d, longint k);
    longint off;
    if (d == 0 || 2 * n > d) return 1'b0;
    off = d - d / 2;
    return (k * n + off) / d != ((k - 1) * n + off) / d;
  endfunction

  initial begin
    for (int i = 0; i < NCH; i++) begin
      pc[i] = 0;
      pcb[i] = 0;
    end
  end

  // reference model: one expected output word per edge
  always @(posedge clk) begin
    exp_t e;
    bit lku;
    e = '0;
    if (!rst_n) begin
      m_s1 = 0;
      m_lk = 0;
      m_rdy = 0;
      m_run = 0;
      for (int i = 0; i < NCH; i++) begin
        m_num[i] = 1;
        m_den[i] = 4;
        m_k[i] = 0;
      end
    end else begin
      lku = m_lk;
      m_lk = m_s1;
      m_s1 = pll_locked;
      m_run = lku ? m_run + 1 : 0;
      for (int i = 0; i < NCH; i++) begin
        if (cfg_wr && cfg_ch == 3'(i)) begin
          m_num[i] = longint'(cfg_num);
          m_den[i] = longint'(cfg_den);
          m_k[i] = 0;
        end else if (!lku || !m_rdy) begin
          m_k[i] = 0;
        end else if (!pause) begin
          m_k[i]++;
          e.c[i] = f_cen(m_num[i], m_den[i], m_k[i]);
          e.b[i] = f_cenb(m_num[i], m_den[i], m_k[i]);
        end
      end
      m_rdy = lku && (m_run >= LC + 1);
      e.rdy = m_rdy;
      e.rst = m_rdy;
    end
    q.push_back(e);
  end

  // monitor: pop and compare each presented output word
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    cyc_no++;
    if (q.size() > 0) begin
      e = q.pop_front();
      a.rdy = ready;
      a.rst = rst_out_n;
      a.c = cen;
      a.b = cen_b;
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL outputs cyc=%0d got rdy=%b rst=%b cen=%b cen_b=%b want rdy=%b rst=%b cen=%b cen_b=%b",
                 cyc_no, a.rdy, a.rst, a.c, a.b,
                 e.rdy, e.rst, e.c, e.b);
      end
      for (int i = 0; i < NCH; i++) begin
        if (cen[i] === 1'b1) pc[i]++;
        if (cen_b[i] === 1'b1) pcb[i]++;
      end
    end
  end

  task automatic chk(string nm, longint got, longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wr(int ch, int n, int d);
    cfg_wr = 1'b1;
    cfg_ch = 3'(ch);
    cfg_num = W'(n);
    cfg_den = W'(d);
    cyc(1);
    cfg_wr = 1'b0;
  endtask

  task automatic wait_ready(output int cy);
    cy = 0;
    while (ready !== 1'b1 && cy < 100) begin
      cyc(1);
      cy++;
    end
  endtask

  int cy, n, b0, b1, bb, drop, r;

  initial begin
    rst_n = 1'b0;
    cyc(3);
    chk("reset_ready", ready, 0);
    chk("reset_rst_out", rst_out_n, 0);
    chk("reset_cen", cen, 0);
    rst_n = 1'b1;
    cyc(2);

    pll_locked = 1'b1;
    wait_ready(cy);
    chk("lock_delay", cy, 11);

    b0 = pc[0];
    b1 = pcb[0];
    cyc(400);
    chk("rate_1_4_cen", pc[0] - b0, 100);
    chk("rate_1_4_cenb", pcb[0] - b1, 100);

    wr(1, 5, 0);
    wr(0, 3, 10);
    b0 = pc[0];
    b1 = pc[1];
    cyc(1000);
    chk("rate_3_10", pc[0] - b0, 300);
    chk("den0_quiet", pc[1] - b1, 0);

    cyc(13);
    pause = 1'b1;
    bb = 0;
    for (int i = 0; i < NCH; i++) bb += pc[i] + pcb[i];
    cyc(37);
    n = 0;
    for (int i = 0; i < NCH; i++) n += pc[i] + pcb[i];
    chk("pause_quiet", n - bb, 0);
    pause = 1'b0;
    cyc(25);

    wr(2, 1, 2);
    chk("wr_edge_low", cen[2], 0);
    cyc(2);
    chk("wr_first_pulse", cen[2], 1);
    cyc(20);

    pll_locked = 1'b0;
    cyc(1);
    pll_locked = 1'b1;
    n = 1;
    while (ready === 1'b1 && n < 10) begin
      cyc(1);
      n++;
    end
    chk("lock_drop_fast", n <= 3, 1);
    chk("lock_drop_cen", cen, 0);
    wait_ready(cy);
    chk("relock_delay", (n - 1) + cy, 11);
    cyc(30);

    drop = 0;
    for (int t = 0; t < 1500; t++) begin
      r = int'($urandom_range(0, 99));
      cfg_wr = (r < 8);
      cfg_ch = 3'($urandom_range(0, 7));
      cfg_num = W'($urandom_range(0, 12));
      cfg_den = W'($urandom_range(0, 12));
      if (r == 0) cfg_num = W'($urandom_range(0, 65535));
      if ($urandom_range(0, 19) == 0) pause = ~pause;
      if (drop > 0) begin
        drop--;
        if (drop == 0) pll_locked = 1'b1;
      end else if ($urandom_range(0, 149) == 0) begin
        pll_locked = 1'b0;
        drop = int'($urandom_range(1, 3));
      end
      cyc(1);
    end
    cfg_wr = 1'b0;
    pause = 1'b0;
    pll_locked = 1'b1;
    cyc(20);

    rst_n = 1'b0;
    #1;
    chk("async_rst_ready", ready, 0);
    chk("async_rst_cen", cen, 0);
    cyc(2);
    rst_n = 1'b1;
    wait_ready(cy);
    chk("rst_relock_delay", cy, 11);
    b0 = pc[3];
    cyc(400);
    chk("init_restored", pc[3] - b0, 100);

    cyc(2);
    chk("queue_drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
